// File: rtl/program_loader_pkg.sv
// Shared constants, state encoding and helpers for the program loader.
package program_loader_pkg;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned INS_W  = 8;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned LEN_W  = 5;
    localparam int unsigned CNT_W  = 8;

    // Largest entry count a load may request; larger values are clamped to it.
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StRun,
        StDone
    } state_e;

    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
        return (len > LEN_MAX) ? LEN_MAX : len;
    endfunction

endpackage

// File: rtl/program_loader.sv
// Boot/run sequencer: streams a program image into computer_4bit while it is held
// in reset, releases it for a fixed number of cycles, then halts it and captures
// the result.
module program_loader
    import program_loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [CNT_W-1:0]  i_run_cycles,
    input  logic              i_host_valid,
    input  logic [INS_W-1:0]  i_host_ins,
    input  logic [DATA_W-1:0] i_host_data,
    output logic              o_host_ready,
    output logic              o_core_rst,
    output logic [INS_W-1:0]  o_core_ins,
    output logic [DATA_W-1:0] o_core_d_in,
    output logic [ADDR_W-1:0] o_core_ins_address,
    input  logic [DATA_W-1:0] i_core_d_out,
    input  logic              i_core_zf,
    input  logic              i_core_cf,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_result,
    output logic              o_result_zf,
    output logic              o_result_cf
);

    state_e              r_state;
    state_e              w_state_d;
    logic [CNT_W-1:0]    r_cnt;      // entry index in LOAD, cycle index in RUN
    logic [LEN_W-1:0]    r_len_q;
    logic [CNT_W-1:0]    r_run_q;
    logic [INS_W-1:0]    r_core_ins;
    logic [DATA_W-1:0]   r_core_d_in;
    logic [ADDR_W-1:0]   r_core_addr;
    logic [DATA_W-1:0]   r_result;
    logic                r_result_zf;
    logic                r_result_cf;

    logic                w_accept;
    logic                w_handshake;
    logic                w_last_entry;
    logic                w_last_run;

    assign w_accept     = i_start && (i_len != '0) && (r_state == StIdle || r_state == StDone);
    assign w_handshake  = i_host_valid && (r_state == StLoad);
    assign w_last_entry = (r_cnt == ({{(CNT_W-LEN_W){1'b0}}, r_len_q} - CNT_W'(1)));
    assign w_last_run   = (r_cnt == (r_run_q - CNT_W'(1)));

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle, StDone: begin
                if (w_accept) w_state_d = StLoad;
            end
            StLoad: begin
                if (w_handshake && w_last_entry) w_state_d = StSettle;
            end
            StSettle: w_state_d = StRun;
            StRun: begin
                if (w_last_run) w_state_d = StDone;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Shared counter, latched parameters, core write port and result capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_len_q     <= '0;
            r_run_q     <= '0;
            r_core_ins  <= '0;
            r_core_d_in <= '0;
            r_core_addr <= '0;
            r_result    <= '0;
            r_result_zf <= 1'b0;
            r_result_cf <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (w_accept) begin
                        r_len_q     <= sat_len(i_len);
                        // A zero run length still releases the core for one cycle.
                        r_run_q     <= (i_run_cycles == '0) ? CNT_W'(1) : i_run_cycles;
                        r_cnt       <= '0;
                        r_result    <= '0;
                        r_result_zf <= 1'b0;
                        r_result_cf <= 1'b0;
                    end
                end
                StLoad: begin
                    if (w_handshake) begin
                        r_core_ins  <= i_host_ins;
                        r_core_d_in <= i_host_data;
                        r_core_addr <= r_cnt[ADDR_W-1:0];
                        r_cnt       <= r_cnt + CNT_W'(1);
                    end
                end
                StSettle: r_cnt <= '0;
                StRun: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last_run) begin
                        r_result    <= i_core_d_out;
                        r_result_zf <= i_core_zf;
                        r_result_cf <= i_core_cf;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign o_host_ready       = (r_state == StLoad);
    assign o_core_rst         = (r_state != StRun);
    assign o_busy             = (r_state == StLoad) || (r_state == StSettle) || (r_state == StRun);
    assign o_done             = (r_state == StDone);
    assign o_core_ins         = r_core_ins;
    assign o_core_d_in        = r_core_d_in;
    assign o_core_ins_address = r_core_addr;
    assign o_result           = r_result;
    assign o_result_zf        = r_result_zf;
    assign o_result_cf        = r_result_cf;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot and run sequencer for computer_4bit.
- Accepts a program image (instruction byte plus data nibble per address) from a host over a valid/ready stream.
- Writes the image into the core through its load interface (ins, d_in, ins_address) while holding the core in reset.
- Releases the core for a programmed number of cycles, then re-asserts core reset and captures d_out, ZF and CF as the run result.

Parameters:
DEPTH, 16, number of program/data entries (address space of computer_4bit)
ADDR_W, 4, width of core_ins_address
INS_W, 8, instruction width ({operand nibble, opcode nibble})
DATA_W, 4, data nibble width

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a load+run sequence
len  input  5  number of entries to load; sampled on accepted start
run_cycles  input  8  number of cycles core_rst is held low; sampled on accepted start
host_valid  input  1  host entry valid
host_ins  input  8  instruction byte for current entry
host_data  input  4  data nibble for current entry
host_ready  output  1  loader accepts an entry this cycle
core_rst  output  1  drives computer_4bit rst (1 = load/hold, 0 = run)
core_ins  output  8  drives computer_4bit ins
core_d_in  output  4  drives computer_4bit d_in
core_ins_address  output  4  drives computer_4bit ins_address
core_d_out  input  4  computer_4bit d_out
core_zf  input  1  computer_4bit ZF
core_cf  input  1  computer_4bit CF
busy  output  1  high in LOAD, SETTLE, RUN
done  output  1  high in DONE
result  output  4  core_d_out captured at end of run
result_zf  output  1  captured ZF
result_cf  output  1  captured CF

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE next cycle.
  - core_rst=1, host_ready=0, busy=0, done=0.
  - core_ins, core_d_in, core_ins_address, result, result_zf, result_cf all = 0.
  - Applies from any state, including mid-LOAD and mid-RUN.
- States are IDLE, LOAD, SETTLE, RUN, DONE. core_rst=1 in every state except RUN.
- IDLE:
  - Accepts start only when len != 0. start with len=0 is ignored.
  - len > 16 saturates to 16.
  - On accept: latch len_q and run_q, clear entry counter, clear result fields, go to LOAD.
- LOAD:
  - host_ready=1.
  - Handshake = host_valid & host_ready.
  - On handshake: core_ins<=host_ins, core_d_in<=host_data, core_ins_address<=counter (registered, visible next cycle), counter++.
  - Without a handshake, core outputs hold their value. No write is duplicated or skipped.
  - On the handshake where counter == len_q-1: go to SETTLE. host_ready drops in SETTLE, so no further handshake occurs.
  - Address never wraps. The last address written is len_q-1 (at most 15).
- SETTLE:
  - Exactly one cycle, core_rst=1.
  - Guarantees the core samples the final entry while still in reset.
  - Then go to RUN with cycle counter = 0.
- RUN:
  - core_rst=0; counter increments each cycle.
  - On the cycle where counter == run_q-1: capture result<=core_d_out, result_zf<=core_zf, result_cf<=core_cf, then go to DONE.
  - Core is released for exactly run_q cycles; run_q=0 is treated as 1.
- DONE:
  - done=1; core_rst=1 holds the core halted; result is stable.
  - start with len != 0 clears done and enters LOAD, same as IDLE.
- start is ignored in LOAD, SETTLE and RUN.
- host_valid is ignored outside LOAD.
- Latency: the first handshake is possible the cycle after start is accepted. For N entries with continuous valid, core_rst falls at cycle start+N+2.

Decomposition:
- Shared package program_loader_pkg holds:
  - state enum (IDLE, LOAD, SETTLE, RUN, DONE)
  - DEPTH, ADDR_W, INS_W, DATA_W constants
  - the len saturation constant
- Single module; no sub-module. The entry counter and the run counter share one 8-bit counter register.

Test Plan:
- Reset: hold rst=1 for 3 cycles -> core_rst=1, host_ready=0, busy=0, done=0, all data outputs 0.
- Nominal:
  - Stimulus: start with len=6, run_cycles=20; entries 16/0, 02/8, 17/0, 0E/0, 04/0, 0F/0 with continuous valid; core stub drives d_out=8, ZF=0, CF=0.
  - Response: core_ins_address steps 0..5 one per cycle; one SETTLE cycle; core_rst low for exactly 20 cycles; then done=1, result=8, result_zf=0, result_cf=0.
- Backpressure: host_valid toggled 1,0,0,1,0,1 during a len=3 load -> exactly 3 writes at addresses 0,1,2; outputs hold through the gaps.
- Bounds:
  - len=16 -> last address 15, no write to address 0 after it.
  - len=20 -> identical to len=16.
  - start with len=0 -> remains IDLE, busy=0.
- Reset mid-operation: rst asserted on the 5th RUN cycle -> next cycle IDLE, core_rst=1, done=0, result=0.
- Start handling:
  - start during RUN -> ignored, run length unchanged.
  - start in DONE with len=2 -> done=0, LOAD entered, 2 new writes.
